// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between N_REQ requesters.
// Captures the winner's operands, launches the ALU, waits for AluWe (or a timeout) and returns a Done pulse.
module alu_arbiter #(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [N_REQ-1:0]         Req,
  input  logic [N_REQ*DATA_W-1:0]  ReqA,
  input  logic [N_REQ*DATA_W-1:0]  ReqB,
  input  logic [N_REQ*OP_W-1:0]    ReqOp,
  output logic [N_REQ-1:0]         Gnt,
  output logic [N_REQ-1:0]         Done,
  output logic [DATA_W-1:0]        RspResult,
  output logic                     RspZ,
  output logic                     RspV,
  output logic                     RspC,
  output logic                     RspErr,
  output logic [DATA_W-1:0]        AluA,
  output logic [DATA_W-1:0]        AluB,
  output logic [OP_W-1:0]          AluOp,
  output logic                     AluStart,
  input  logic [DATA_W-1:0]        AluResult,
  input  logic                     AluZ,
  input  logic                     AluV,
  input  logic                     AluC,
  input  logic                     AluWe
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;

  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   cand_idx;
  logic               found;
  logic [DATA_W-1:0]  a_arr  [N_REQ];
  logic [DATA_W-1:0]  b_arr  [N_REQ];
  logic [OP_W-1:0]    op_arr [N_REQ];
  logic [IDX_W-1:0]   ptr_next;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      a_arr[k]  = ReqA[k*DATA_W +: DATA_W];
      b_arr[k]  = ReqB[k*DATA_W +: DATA_W];
      op_arr[k] = ReqOp[k*OP_W +: OP_W];
    end
  end

  // Scan ptr, ptr+1, ... (mod N_REQ); the first asserted request wins.
  always_comb begin
    win      = ptr;
    found    = 1'b0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_idx = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found && Req[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  assign ptr_next = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      idx       <= '0;
      cnt       <= '0;
      Gnt       <= '0;
      Done      <= '0;
      RspResult <= '0;
      RspZ      <= 1'b0;
      RspV      <= 1'b0;
      RspC      <= 1'b0;
      RspErr    <= 1'b0;
      AluA      <= '0;
      AluB      <= '0;
      AluOp     <= '0;
      AluStart  <= 1'b0;
    end else begin
      Gnt      <= '0;
      Done     <= '0;
      AluStart <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|Req) begin
            idx      <= win;
            AluA     <= a_arr[win];
            AluB     <= b_arr[win];
            AluOp    <= op_arr[win];
            Gnt      <= N_REQ'(1) << win;
            AluStart <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        // A strobe arriving on the final WAIT cycle still counts as a normal response.
        S_WAIT: begin
          if (AluWe) begin
            RspResult <= AluResult;
            RspZ      <= AluZ;
            RspV      <= AluV;
            RspC      <= AluC;
            RspErr    <= 1'b0;
            Done      <= N_REQ'(1) << idx;
            state     <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            RspResult <= '0;
            RspZ      <= 1'b0;
            RspV      <= 1'b0;
            RspC      <= 1'b0;
            RspErr    <= 1'b1;
            Done      <= N_REQ'(1) << idx;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          ptr   <= ptr_next;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: stub ALU with programmable latency/hang,
// event monitor, and a round-robin reference model working on request masks.
module tb_alu_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int OW = 3;
  localparam int TO = 8;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic [N-1:0]    Req = '0;
  logic [N*DW-1:0] ReqA = '0;
  logic [N*DW-1:0] ReqB = '0;
  logic [N*OW-1:0] ReqOp = '0;
  logic [N-1:0]    Gnt, Done;
  logic [DW-1:0]   RspResult;
  logic            RspZ, RspV, RspC, RspErr;
  logic [DW-1:0]   AluA, AluB;
  logic [OW-1:0]   AluOp;
  logic            AluStart;
  logic [DW-1:0]   AluResult = '0;
  logic            AluZ = 1'b0, AluV = 1'b0, AluC = 1'b0, AluWe = 1'b0;

  alu_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqA(ReqA), .ReqB(ReqB), .ReqOp(ReqOp),
    .Gnt(Gnt), .Done(Done), .RspResult(RspResult), .RspZ(RspZ), .RspV(RspV), .RspC(RspC),
    .RspErr(RspErr), .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluStart(AluStart),
    .AluResult(AluResult), .AluZ(AluZ), .AluV(AluV), .AluC(AluC), .AluWe(AluWe)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference ALU behaviour, shared by the stub and the expected-value side.
  function automatic logic [DW-1:0] alu_res(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return (b == '0) ? '0 : a % b;
    endcase
  endfunction

  function automatic logic alu_c(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (op == 3'd0) && s[DW];
  endfunction

  // Stub ALU: responds stub_lat cycles after AluStart unless hung.
  int stub_cnt = 0;
  int stub_lat = 2;
  bit stub_hang = 1'b0;

  initial begin
    forever begin
      @(negedge Clk);
      AluWe = 1'b0;
      if (!Reset) stub_cnt = 0;
      else if (AluStart) stub_cnt = stub_lat;
      else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0 && !stub_hang) begin
          AluWe     = 1'b1;
          AluResult = alu_res(AluA, AluB, AluOp);
          AluZ      = (AluResult == '0);
          AluC      = alu_c(AluA, AluB, AluOp);
          AluV      = ^AluResult;
        end
      end
    end
  end

  typedef struct {
    int            cyc;
    int            idx;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
  } gnt_t;

  typedef struct {
    int            cyc;
    int            idx;
    logic [DW-1:0] res;
    logic          z, v, c, err;
  } done_t;

  gnt_t  gnt_q[$];
  done_t done_q[$];
  int    cyc = 0;
  int    bad_onehot = 0;
  int    overlap = 0;
  int    start_cnt = 0;

  function automatic int first_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge Clk) begin
    cyc++;
    if (Gnt != '0) gnt_q.push_back('{cyc, first_idx(Gnt), AluA, AluB, AluOp});
    if (Done != '0) done_q.push_back('{cyc, first_idx(Done), RspResult, RspZ, RspV, RspC, RspErr});
    if ($countones(Gnt) > 1 || $countones(Done) > 1) bad_onehot++;
    if (Gnt != '0 && Done != '0) overlap++;
    if (AluStart === 1'b1) start_cnt++;
  end

  // Requester operand table and round-robin pointer of the reference model.
  logic [DW-1:0] ra [N];
  logic [DW-1:0] rb [N];
  logic [OW-1:0] rop [N];
  int model_ptr = 0;

  function automatic int model_pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++) if (m[(model_ptr + k) % N]) return (model_ptr + k) % N;
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clk);
      #1;
    end
  endtask

  task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    ra[i] = a;
    rb[i] = b;
    rop[i] = op;
    ReqA[i*DW +: DW] = a;
    ReqB[i*DW +: DW] = b;
    ReqOp[i*OW +: OW] = op;
  endtask

  task automatic rand_ops();
    logic [DW-1:0] b;
    for (int i = 0; i < N; i++) begin
      b = $urandom;
      if (b == '0) b = 1;
      set_ops(i, $urandom, b, OW'($urandom_range(0, 7)));
    end
  endtask

  task automatic wait_gnts(input int n, input int budget);
    for (int i = 0; i < budget && gnt_q.size() < n; i++) tick(1);
  endtask

  task automatic wait_dones(input int n, input int budget);
    for (int i = 0; i < budget && done_q.size() < n; i++) tick(1);
  endtask

  task automatic clear_logs();
    gnt_q.delete();
    done_q.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Req = '0;
    tick(2);
    checks++;
    if ({Gnt, Done} !== '0) begin errors++; $display("[TB] FAIL reset_gnt_done: got %b/%b expected 0", Gnt, Done); end
    checks++;
    if ({RspResult, RspZ, RspV, RspC, RspErr} !== '0) begin errors++; $display("[TB] FAIL reset_rsp: got %h err=%b expected 0", RspResult, RspErr); end
    checks++;
    if ({AluA, AluB, AluOp, AluStart} !== '0) begin errors++; $display("[TB] FAIL reset_alu: got A=%h B=%h op=%h st=%b expected 0", AluA, AluB, AluOp, AluStart); end
    Reset = 1'b1;
    clear_logs();
    tick(4);
    checks++;
    if (gnt_q.size() !== 0) begin errors++; $display("[TB] FAIL idle_no_grant: got %0d grants expected 0", gnt_q.size()); end
    model_ptr = 0;
  endtask

  task automatic test_both_req();
    int exp_idx [2];
    exp_idx = '{0, 1};
    clear_logs();
    rand_ops();
    stub_lat = $urandom_range(1, 4);
    Req = 3'b011;
    wait_dones(2, 100);
    Req = '0;
    tick(4);
    checks++;
    if (gnt_q.size() !== 2 || done_q.size() !== 2) begin
      errors++; $display("[TB] FAIL both_req_count: got %0d grants %0d dones expected 2/2", gnt_q.size(), done_q.size());
    end else begin
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (gnt_q[j].idx !== exp_idx[j]) begin errors++; $display("[TB] FAIL both_req_gnt%0d: got %0d expected %0d", j, gnt_q[j].idx, exp_idx[j]); end
        checks++;
        if (done_q[j].idx !== exp_idx[j]) begin errors++; $display("[TB] FAIL both_req_done%0d: got %0d expected %0d", j, done_q[j].idx, exp_idx[j]); end
        checks++;
        if (done_q[j].res !== alu_res(ra[j], rb[j], rop[j])) begin
          errors++; $display("[TB] FAIL both_req_res%0d: got %h expected %h", j, done_q[j].res, alu_res(ra[j], rb[j], rop[j]));
        end
      end
    end
    model_ptr = 2;
  endtask

  task automatic test_mod();
    int s0;
    clear_logs();
    set_ops(0, 32'd16, 32'd5, 3'd7);
    stub_lat = 3;
    s0 = start_cnt;
    Req = 3'b001;
    wait_gnts(1, 20);
    Req = '0;
    wait_dones(1, 40);
    tick(3);
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("[TB] FAIL mod_start_pulse: got %0d start cycles expected 1", start_cnt - s0); end
    checks++;
    if (gnt_q.size() !== 1 || done_q.size() !== 1) begin
      errors++; $display("[TB] FAIL mod_count: got %0d grants %0d dones expected 1/1", gnt_q.size(), done_q.size());
    end else begin
      checks++;
      if ({gnt_q[0].a, gnt_q[0].b, gnt_q[0].op} !== {32'd16, 32'd5, 3'd7}) begin
        errors++; $display("[TB] FAIL mod_operands: got A=%0d B=%0d op=%0d expected 16/5/7", gnt_q[0].a, gnt_q[0].b, gnt_q[0].op);
      end
      checks++;
      if (done_q[0].idx !== 0) begin errors++; $display("[TB] FAIL mod_done_idx: got %0d expected 0", done_q[0].idx); end
      checks++;
      if (done_q[0].res !== 32'd1 || done_q[0].err !== 1'b0 || done_q[0].z !== 1'b0) begin
        errors++; $display("[TB] FAIL mod_result: got %0d err=%b z=%b expected 1 err=0 z=0", done_q[0].res, done_q[0].err, done_q[0].z);
      end
      checks++;
      if (done_q[0].cyc - gnt_q[0].cyc !== 4) begin errors++; $display("[TB] FAIL mod_latency: got %0d expected 4", done_q[0].cyc - gnt_q[0].cyc); end
    end
    checks++;
    if (AluA !== 32'd16 || RspResult !== 32'd1) begin
      errors++; $display("[TB] FAIL mod_hold: got AluA=%0d Rsp=%0d expected 16/1", AluA, RspResult);
    end
    model_ptr = 1;
  endtask

  task automatic test_no_starve();
    int exp_idx [4];
    exp_idx = '{0, 1, 0, 1};
    clear_logs();
    rand_ops();
    stub_lat = $urandom_range(1, 4);
    Req = 3'b001;
    wait_gnts(1, 20);
    Req = 3'b011;
    wait_dones(4, 200);
    Req = '0;
    tick(4);
    checks++;
    if (gnt_q.size() !== 4 || done_q.size() !== 4) begin
      errors++; $display("[TB] FAIL no_starve_count: got %0d grants %0d dones expected 4/4", gnt_q.size(), done_q.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (gnt_q[j].idx !== exp_idx[j] || done_q[j].idx !== exp_idx[j]) begin
          errors++; $display("[TB] FAIL no_starve_order%0d: got gnt=%0d done=%0d expected %0d", j, gnt_q[j].idx, done_q[j].idx, exp_idx[j]);
        end
      end
    end
    model_ptr = 2;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] mask;
    int e;
    for (int it = 0; it < 4; it++) begin
      clear_logs();
      rand_ops();
      stub_lat = $urandom_range(1, 5);
      mask = N'($urandom_range(1, 7));
      Req = mask;
      wait_dones(3, 200);
      Req = '0;
      tick(4);
      checks++;
      if (gnt_q.size() !== 3 || done_q.size() !== 3) begin
        errors++; $display("[TB] FAIL rr_count it%0d: got %0d grants %0d dones expected 3/3", it, gnt_q.size(), done_q.size());
      end else begin
        for (int j = 0; j < 3; j++) begin
          e = model_pick(mask);
          checks++;
          if (gnt_q[j].idx !== e || done_q[j].idx !== e) begin
            errors++; $display("[TB] FAIL rr_winner it%0d op%0d mask=%b: got gnt=%0d done=%0d expected %0d", it, j, mask, gnt_q[j].idx, done_q[j].idx, e);
          end
          checks++;
          if (gnt_q[j].a !== ra[e] || gnt_q[j].b !== rb[e] || gnt_q[j].op !== rop[e]) begin
            errors++; $display("[TB] FAIL rr_operands it%0d op%0d: got A=%h B=%h op=%0d expected A=%h B=%h op=%0d", it, j, gnt_q[j].a, gnt_q[j].b, gnt_q[j].op, ra[e], rb[e], rop[e]);
          end
          checks++;
          if (done_q[j].res !== alu_res(ra[e], rb[e], rop[e]) || done_q[j].err !== 1'b0 ||
              done_q[j].c !== alu_c(ra[e], rb[e], rop[e])) begin
            errors++; $display("[TB] FAIL rr_result it%0d op%0d: got %h c=%b err=%b expected %h c=%b err=0", it, j, done_q[j].res, done_q[j].c, done_q[j].err, alu_res(ra[e], rb[e], rop[e]), alu_c(ra[e], rb[e], rop[e]));
          end
          model_ptr = (e + 1) % N;
        end
      end
    end
  endtask

  task automatic test_timeout();
    int e;
    clear_logs();
    rand_ops();
    stub_hang = 1'b1;
    e = model_pick(3'b100);
    Req = 3'b100;
    wait_gnts(1, 20);
    Req = '0;
    wait_dones(1, TO + 20);
    tick(3);
    checks++;
    if (gnt_q.size() !== 1 || done_q.size() !== 1) begin
      errors++; $display("[TB] FAIL timeout_count: got %0d grants %0d dones expected 1/1", gnt_q.size(), done_q.size());
    end else begin
      checks++;
      if (done_q[0].idx !== e) begin errors++; $display("[TB] FAIL timeout_idx: got %0d expected %0d", done_q[0].idx, e); end
      checks++;
      if (done_q[0].err !== 1'b1 || done_q[0].res !== '0 || {done_q[0].z, done_q[0].v, done_q[0].c} !== 3'b000) begin
        errors++; $display("[TB] FAIL timeout_rsp: got err=%b res=%h flags=%b%b%b expected err=1 res=0 flags=000", done_q[0].err, done_q[0].res, done_q[0].z, done_q[0].v, done_q[0].c);
      end
      checks++;
      if (done_q[0].cyc - gnt_q[0].cyc !== TO + 1) begin
        errors++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", done_q[0].cyc - gnt_q[0].cyc, TO + 1);
      end
    end
    checks++;
    if (RspErr !== 1'b1) begin errors++; $display("[TB] FAIL timeout_hold: got RspErr=%b expected 1", RspErr); end
    model_ptr = (e + 1) % N;
    stub_hang = 1'b0;
  endtask

  task automatic test_timeout_boundary();
    logic [N-1:0] mask;
    int e;
    bit late;
    for (int k = 0; k < 2; k++) begin
      late = (k == 1);
      clear_logs();
      rand_ops();
      stub_lat = TO + k;
      mask = N'($urandom_range(1, 7));
      e = model_pick(mask);
      Req = mask;
      wait_gnts(1, 20);
      Req = '0;
      wait_dones(1, TO + 20);
      tick(3);
      checks++;
      if (done_q.size() !== 1 || gnt_q.size() !== 1) begin
        errors++; $display("[TB] FAIL edge_count lat=%0d: got %0d grants %0d dones expected 1/1", TO + k, gnt_q.size(), done_q.size());
      end else begin
        checks++;
        if (done_q[0].idx !== e || done_q[0].err !== late) begin
          errors++; $display("[TB] FAIL edge_err lat=%0d: got idx=%0d err=%b expected idx=%0d err=%b", TO + k, done_q[0].idx, done_q[0].err, e, late);
        end
        checks++;
        if (done_q[0].res !== (late ? '0 : alu_res(ra[e], rb[e], rop[e]))) begin
          errors++; $display("[TB] FAIL edge_res lat=%0d: got %h expected %h", TO + k, done_q[0].res, late ? '0 : alu_res(ra[e], rb[e], rop[e]));
        end
        checks++;
        if (done_q[0].cyc - gnt_q[0].cyc !== TO + 1) begin
          errors++; $display("[TB] FAIL edge_latency lat=%0d: got %0d expected %0d", TO + k, done_q[0].cyc - gnt_q[0].cyc, TO + 1);
        end
      end
      model_ptr = (e + 1) % N;
    end
  endtask

  task automatic test_drop_while_busy();
    int e;
    clear_logs();
    rand_ops();
    stub_lat = 6;
    e = model_pick(3'b001);
    Req = 3'b001;
    wait_gnts(1, 20);
    Req = '0;
    tick(2);
    Req = 3'b100;
    tick(2);
    Req = '0;
    wait_dones(1, 40);
    tick(6);
    checks++;
    if (gnt_q.size() !== 1) begin
      errors++; $display("[TB] FAIL drop_busy_grants: got %0d grants expected 1", gnt_q.size());
    end else begin
      checks++;
      if (gnt_q[0].idx !== e) begin errors++; $display("[TB] FAIL drop_busy_idx: got %0d expected %0d", gnt_q[0].idx, e); end
    end
    model_ptr = (e + 1) % N;
  endtask

  task automatic test_reset_mid_wait();
    int e;
    clear_logs();
    rand_ops();
    stub_hang = 1'b1;
    Req = 3'b010;
    wait_gnts(1, 20);
    Req = '0;
    tick(3);
    Reset = 1'b0;
    #1;
    checks++;
    if ({Gnt, Done, AluStart} !== '0) begin errors++; $display("[TB] FAIL midreset_pulses: got gnt=%b done=%b st=%b expected 0", Gnt, Done, AluStart); end
    checks++;
    if ({RspResult, RspZ, RspV, RspC, RspErr} !== '0) begin errors++; $display("[TB] FAIL midreset_rsp: got %h err=%b expected 0", RspResult, RspErr); end
    checks++;
    if ({AluA, AluB, AluOp} !== '0) begin errors++; $display("[TB] FAIL midreset_alu: got A=%h B=%h op=%h expected 0", AluA, AluB, AluOp); end
    tick(3);
    checks++;
    if (done_q.size() !== 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d dones expected 0", done_q.size()); end
    Reset = 1'b1;
    stub_hang = 1'b0;
    model_ptr = 0;
    tick(1);
    clear_logs();
    e = model_pick(3'b111);
    Req = 3'b111;
    wait_gnts(1, 20);
    Req = '0;
    wait_dones(1, 40);
    tick(3);
    checks++;
    if (gnt_q.size() !== 1 || done_q.size() !== 1) begin
      errors++; $display("[TB] FAIL postreset_count: got %0d grants %0d dones expected 1/1", gnt_q.size(), done_q.size());
    end else begin
      checks++;
      if (gnt_q[0].idx !== e || done_q[0].res !== alu_res(ra[e], rb[e], rop[e])) begin
        errors++; $display("[TB] FAIL postreset_grant: got idx=%0d res=%h expected idx=%0d res=%h", gnt_q[0].idx, done_q[0].res, e, alu_res(ra[e], rb[e], rop[e]));
      end
    end
    model_ptr = (e + 1) % N;
  endtask

  task automatic test_invariants();
    checks++;
    if (bad_onehot !== 0) begin errors++; $display("[TB] FAIL onehot: got %0d non-onehot cycles expected 0", bad_onehot); end
    checks++;
    if (overlap !== 0) begin errors++; $display("[TB] FAIL gnt_done_overlap: got %0d cycles expected 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_both_req();
    test_mod();
    test_no_starve();
    test_round_robin();
    test_timeout();
    test_timeout_boundary();
    test_drop_while_busy();
    test_reset_mid_wait();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
